// File: rtl/phase_collector.sv
// phase_collector
// Receiving end of the phase/step output stream. Per-beat {mem_op, mem_data}
// words are reassembled into an L-row by K-column result buffer (K/N words of
// N bits per row). Once row L-1 closes, or a FAIL op arrives, the buffer is
// replayed row-major over a valid/ready stream.
//
// Ports:
//   clk, rst       clock; asynchronous active-low reset
//   start          arm pulse: clears pointers/flags and enters COLLECT
//   mem_data_in    N-bit data beat
//   mem_op_in      3 bits of op per lane; the lane 0 op is the beat op
//   collecting     high while in COLLECT
//   done           one-cycle pulse when row L-1 completes
//   fail           sticky: FAIL op received this run
//   err            sticky: protocol violation this run
//   overflow       sticky: non-IDLE beat arrived outside COLLECT
//   rows_written   completed rows this run (saturates at L)
//   out_data       readout word
//   out_valid      readout word valid
//   out_ready      downstream accepts the word
//   out_last       high with the final word (row L-1, block K/N-1)
module phase_collector #(
    parameter int N = 4,
    parameter int L = 8,
    parameter int K = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N-1:0]             mem_data_in,
    input  logic [3*N-1:0]           mem_op_in,
    output logic                     collecting,
    output logic                     done,
    output logic                     fail,
    output logic                     err,
    output logic                     overflow,
    output logic [$clog2(L+1)-1:0]   rows_written,
    output logic [N-1:0]             out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last
);

    localparam int KB    = K / N;
    localparam int W     = L * KB;
    localparam int RW    = $clog2(L + 1);
    localparam int AW    = (W > 1) ? $clog2(W) : 1;
    localparam int CW    = (KB > 1) ? $clog2(KB) : 1;
    localparam int ROW_W = (L > 1) ? $clog2(L) : 1;

    localparam logic [2:0] OP_IDLE      = 3'b000;
    localparam logic [2:0] OP_DATA      = 3'b001;
    localparam logic [2:0] OP_DATA_LAST = 3'b011;
    localparam logic [2:0] OP_FAIL      = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_COLLECT = 2'b01,
        S_DRAIN   = 2'b10
    } state_t;

    // True when any upper lane carries a different op than lane 0.
    function automatic logic lanes_differ(input logic [3*N-1:0] ops);
        logic diff;
        diff = 1'b0;
        for (int i = 1; i < N; i++) begin
            if (ops[3*i +: 3] != ops[2:0]) begin
                diff = 1'b1;
            end else begin
                diff = diff;
            end
        end
        return diff;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [ROW_W-1:0] row_ptr_r, row_ptr_nxt_s;
    logic [CW-1:0]    col_ptr_r, col_ptr_nxt_s;
    logic [RW-1:0]    rows_written_r, rows_written_nxt_s;
    logic [AW-1:0]    rd_ptr_r, rd_ptr_nxt_s;
    logic             fail_r, fail_nxt_s;
    logic             err_r, err_nxt_s;
    logic             overflow_r, overflow_nxt_s;
    logic             done_r, done_nxt_s;
    logic             collecting_r, collecting_nxt_s;
    logic             out_valid_r, out_valid_nxt_s;
    logic             out_last_r, out_last_nxt_s;
    logic [N-1:0]     out_data_r, out_data_nxt_s;

    logic [N-1:0]     mem_r [W];
    logic             mem_we_s;
    logic [AW-1:0]    wr_addr_s;
    logic [N-1:0]     mem_rd_s;
    logic [2:0]       op0_s;
    logic             beat_active_s;
    logic             lane_err_s;

    assign op0_s         = mem_op_in[2:0];
    assign beat_active_s = (op0_s != OP_IDLE);
    assign lane_err_s    = lanes_differ(mem_op_in);
    assign wr_addr_s     = AW'(row_ptr_r) * AW'(KB) + AW'(col_ptr_r);
    assign mem_rd_s      = mem_r[rd_ptr_r];

    // Next-state and next-output logic for the collect/drain sequencer.
    always_comb begin
        state_nxt_s        = state_r;
        row_ptr_nxt_s      = row_ptr_r;
        col_ptr_nxt_s      = col_ptr_r;
        rows_written_nxt_s = rows_written_r;
        rd_ptr_nxt_s       = rd_ptr_r;
        fail_nxt_s         = fail_r;
        err_nxt_s          = err_r;
        overflow_nxt_s     = overflow_r;
        done_nxt_s         = 1'b0;
        out_valid_nxt_s    = out_valid_r;
        out_last_nxt_s     = out_last_r;
        out_data_nxt_s     = out_data_r;
        mem_we_s           = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s        = S_COLLECT;
                    row_ptr_nxt_s      = '0;
                    col_ptr_nxt_s      = '0;
                    rows_written_nxt_s = '0;
                    rd_ptr_nxt_s       = '0;
                    fail_nxt_s         = 1'b0;
                    err_nxt_s          = 1'b0;
                    overflow_nxt_s     = 1'b0;
                end else begin
                    overflow_nxt_s = overflow_r | beat_active_s;
                end
            end

            S_COLLECT: begin
                if (start) begin
                    // Re-arm: any beat in this cycle is dropped.
                    row_ptr_nxt_s      = '0;
                    col_ptr_nxt_s      = '0;
                    rows_written_nxt_s = '0;
                    rd_ptr_nxt_s       = '0;
                    fail_nxt_s         = 1'b0;
                    err_nxt_s          = 1'b0;
                    overflow_nxt_s     = 1'b0;
                end else begin
                    // A lane mismatch flags err but the lane 0 op still runs.
                    err_nxt_s = err_r | lane_err_s;
                    case (op0_s)
                        OP_IDLE: begin
                            mem_we_s = 1'b0;
                        end
                        OP_DATA: begin
                            mem_we_s = 1'b1;
                            if (col_ptr_r == CW'(KB - 1)) begin
                                // Row already full: hold col, later beats overwrite.
                                err_nxt_s = 1'b1;
                            end else begin
                                col_ptr_nxt_s = col_ptr_r + CW'(1);
                            end
                        end
                        OP_DATA_LAST: begin
                            mem_we_s      = 1'b1;
                            col_ptr_nxt_s = '0;
                            row_ptr_nxt_s = row_ptr_r + ROW_W'(1);
                            if (col_ptr_r != CW'(KB - 1)) begin
                                err_nxt_s = 1'b1;
                            end else begin
                                err_nxt_s = err_nxt_s;
                            end
                            if (rows_written_r != RW'(L)) begin
                                rows_written_nxt_s = rows_written_r + RW'(1);
                            end else begin
                                rows_written_nxt_s = rows_written_r;
                            end
                            if (row_ptr_r == ROW_W'(L - 1)) begin
                                done_nxt_s   = 1'b1;
                                state_nxt_s  = S_DRAIN;
                                rd_ptr_nxt_s = '0;
                            end else begin
                                state_nxt_s = S_COLLECT;
                            end
                        end
                        OP_FAIL: begin
                            fail_nxt_s   = 1'b1;
                            state_nxt_s  = S_DRAIN;
                            rd_ptr_nxt_s = '0;
                        end
                        default: begin
                            err_nxt_s = 1'b1;
                        end
                    endcase
                end
            end

            S_DRAIN: begin
                overflow_nxt_s = overflow_r | beat_active_s;
                if (!out_valid_r) begin
                    // First DRAIN cycle: present word 0.
                    out_valid_nxt_s = 1'b1;
                    out_data_nxt_s  = mem_rd_s;
                    out_last_nxt_s  = (rd_ptr_r == AW'(W - 1));
                    rd_ptr_nxt_s    = rd_ptr_r + AW'(1);
                end else if (out_ready) begin
                    if (out_last_r) begin
                        out_valid_nxt_s = 1'b0;
                        out_last_nxt_s  = 1'b0;
                        state_nxt_s     = S_IDLE;
                    end else begin
                        out_data_nxt_s = mem_rd_s;
                        out_last_nxt_s = (rd_ptr_r == AW'(W - 1));
                        rd_ptr_nxt_s   = rd_ptr_r + AW'(1);
                    end
                end else begin
                    out_valid_nxt_s = out_valid_r;
                end
            end

            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase

        collecting_nxt_s = (state_nxt_s == S_COLLECT);
    end

    // Control and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= S_IDLE;
            row_ptr_r      <= '0;
            col_ptr_r      <= '0;
            rows_written_r <= '0;
            rd_ptr_r       <= '0;
            fail_r         <= 1'b0;
            err_r          <= 1'b0;
            overflow_r     <= 1'b0;
            done_r         <= 1'b0;
            collecting_r   <= 1'b0;
            out_valid_r    <= 1'b0;
            out_last_r     <= 1'b0;
            out_data_r     <= '0;
        end else begin
            state_r        <= state_nxt_s;
            row_ptr_r      <= row_ptr_nxt_s;
            col_ptr_r      <= col_ptr_nxt_s;
            rows_written_r <= rows_written_nxt_s;
            rd_ptr_r       <= rd_ptr_nxt_s;
            fail_r         <= fail_nxt_s;
            err_r          <= err_nxt_s;
            overflow_r     <= overflow_nxt_s;
            done_r         <= done_nxt_s;
            collecting_r   <= collecting_nxt_s;
            out_valid_r    <= out_valid_nxt_s;
            out_last_r     <= out_last_nxt_s;
            out_data_r     <= out_data_nxt_s;
        end
    end

    // Result buffer write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[wr_addr_s] <= mem_data_in;
        end
    end

    assign collecting   = collecting_r;
    assign done         = done_r;
    assign fail         = fail_r;
    assign err          = err_r;
    assign overflow     = overflow_r;
    assign rows_written = rows_written_r;
    assign out_data     = out_data_r;
    assign out_valid    = out_valid_r;
    assign out_last     = out_last_r;

endmodule

// File: tb/tb_phase_collector.sv
// Directed testbench for phase_collector (N=4, L=8, K=16).
module tb_phase_collector;

    localparam logic [2:0] D    = 3'b001;
    localparam logic [2:0] DL   = 3'b011;
    localparam logic [2:0] FOP  = 3'b100;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  mem_data_in;
    logic [11:0] mem_op_in;
    logic        collecting;
    logic        done;
    logic        fail;
    logic        err;
    logic        overflow;
    logic [3:0]  rows_written;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] expw [32];
    bit         expv [32];

    phase_collector #(.N(4), .L(8), .K(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mem_data_in  (mem_data_in),
        .mem_op_in    (mem_op_in),
        .collecting   (collecting),
        .done         (done),
        .fail         (fail),
        .err          (err),
        .overflow     (overflow),
        .rows_written (rows_written),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [2:0] op, input logic [3:0] d);
        mem_op_in   = {4{op}};
        mem_data_in = d;
        tick();
        mem_op_in   = 12'h000;
        mem_data_in = 4'h0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Beats for word addresses [from, to): DATA x3 then DATA_LAST, data = address.
    task automatic write_beats(input int from, input int to);
        for (int b = from; b < to; b++) begin
            beat(((b % 4) == 3) ? DL : D, 4'(b));
        end
    endtask

    task automatic set_exp_default();
        for (int i = 0; i < 32; i++) begin
            expw[i] = 4'(i);
            expv[i] = 1'b1;
        end
    endtask

    // Consume n_xfer words; bp applies a 1,0,0 ready pattern.
    task automatic drain(input int n_xfer, input bit bp);
        int         got;
        int         cyc;
        logic [3:0] prev_d;
        logic       prev_l;
        bit         prev_stall;
        got = 0;
        cyc = 0;
        prev_d = 4'h0;
        prev_l = 1'b0;
        prev_stall = 1'b0;
        while (got < n_xfer && cyc < 300) begin
            out_ready = bp ? ((cyc % 3) == 0) : 1'b1;
            if (out_valid) begin
                if (prev_stall) begin
                    chk("hold_data", out_data, prev_d);
                    chk("hold_last", out_last, prev_l);
                end
                if (out_ready) begin
                    if (expv[got]) chk($sformatf("word%0d", got), out_data, expw[got]);
                    chk($sformatf("last%0d", got), out_last, (got == 31));
                    got++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_d = out_data;
                    prev_l = out_last;
                end
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        chk("drain_count", got, n_xfer);
        if (n_xfer == 32) begin
            chk("valid_drop", out_valid, 1'b0);
            chk("collecting_after_drain", collecting, 1'b0);
            if (!bp) chk("drain_cycles", cyc, 33);
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        mem_op_in = 12'h000;
        mem_data_in = 4'h0;
        out_ready = 1'b0;
        set_exp_default();
        tick();
        tick();
        chk("rst_collecting", collecting, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_fail", fail, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_rows", rows_written, 4'd0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 4'h0);
        chk("rst_last", out_last, 1'b0);
        rst = 1'b1;
        tick();

        // Nominal run
        pulse_start();
        chk("nom_collecting", collecting, 1'b1);
        write_beats(0, 31);
        chk("nom_done_early", done, 1'b0);
        chk("nom_rows7", rows_written, 4'd7);
        write_beats(31, 32);
        chk("nom_done", done, 1'b1);
        chk("nom_rows8", rows_written, 4'd8);
        chk("nom_not_collecting", collecting, 1'b0);
        chk("nom_valid_latency", out_valid, 1'b0);
        drain(32, 1'b0);
        chk("nom_done_gone", done, 1'b0);
        chk("nom_err", err, 1'b0);
        chk("nom_fail", fail, 1'b0);
        chk("nom_overflow", overflow, 1'b0);

        // Backpressure run
        pulse_start();
        write_beats(0, 32);
        chk("bp_done", done, 1'b1);
        drain(32, 1'b1);
        chk("bp_err", err, 1'b0);

        // Protocol errors
        pulse_start();
        beat(D, 4'h0);
        chk("pe_err_clean", err, 1'b0);
        beat(DL, 4'h1);
        chk("pe_err_short_row", err, 1'b1);
        chk("pe_rows_short", rows_written, 4'd1);
        mem_op_in = {3'b001, 3'b011, 3'b001, 3'b001};
        mem_data_in = 4'h4;
        tick();
        mem_op_in = 12'h000;
        chk("pe_err_held", err, 1'b1);
        write_beats(5, 32);
        chk("pe_done", done, 1'b1);
        chk("pe_rows8", rows_written, 4'd8);
        expv[2] = 1'b0;
        expv[3] = 1'b0;
        drain(32, 1'b0);
        set_exp_default();
        chk("pe_err_through_drain", err, 1'b1);
        pulse_start();
        chk("pe_err_cleared", err, 1'b0);
        mem_op_in = {3'b000, 3'b000, 3'b001, 3'b000};
        tick();
        mem_op_in = 12'h000;
        chk("pe_lane_mismatch", err, 1'b1);
        chk("pe_lane_rows", rows_written, 4'd0);
        pulse_start();
        beat(3'b010, 4'h0);
        chk("pe_illegal_op", err, 1'b1);
        pulse_start();
        write_beats(0, 3);
        chk("pe_col_ok", err, 1'b0);
        beat(D, 4'h3);
        chk("pe_col_overrun", err, 1'b1);
        chk("pe_col_rows", rows_written, 4'd0);

        // Fail after three rows
        pulse_start();
        chk("fl_rearm_err", err, 1'b0);
        write_beats(0, 12);
        chk("fl_rows3", rows_written, 4'd3);
        beat(FOP, 4'h0);
        chk("fl_fail", fail, 1'b1);
        chk("fl_no_done", done, 1'b0);
        chk("fl_not_collecting", collecting, 1'b0);
        for (int i = 12; i < 32; i++) expv[i] = 1'b0;
        drain(32, 1'b0);
        set_exp_default();
        chk("fl_fail_sticky", fail, 1'b1);

        // Overflow and re-arm
        beat(D, 4'h5);
        chk("ov_set", overflow, 1'b1);
        chk("ov_idle", collecting, 1'b0);
        pulse_start();
        chk("ov_cleared", overflow, 1'b0);
        chk("ov_fail_cleared", fail, 1'b0);
        for (int b = 0; b < 5; b++) beat(((b % 4) == 3) ? DL : D, ~4'(b));
        chk("ov_rows1", rows_written, 4'd1);
        start = 1'b1;
        mem_op_in = {4{D}};
        mem_data_in = 4'h9;
        tick();
        start = 1'b0;
        mem_op_in = 12'h000;
        chk("ov_rearm_rows", rows_written, 4'd0);
        chk("ov_rearm_collecting", collecting, 1'b1);
        write_beats(0, 32);
        chk("ov_done", done, 1'b1);
        chk("ov_err", err, 1'b0);
        drain(32, 1'b0);

        // Reset in the middle of DRAIN
        pulse_start();
        write_beats(0, 32);
        drain(10, 1'b0);
        chk("rd_valid_before", out_valid, 1'b1);
        chk("rd_data_before", out_data, 4'hA);
        rst = 1'b0;
        #2;
        chk("rd_valid", out_valid, 1'b0);
        chk("rd_data", out_data, 4'h0);
        chk("rd_last", out_last, 1'b0);
        chk("rd_rows", rows_written, 4'd0);
        chk("rd_collecting", collecting, 1'b0);
        chk("rd_flags", {fail, err, overflow, done}, 4'h0);
        tick();
        rst = 1'b1;
        beat(D, 4'h3);
        chk("rd_ignored_rows", rows_written, 4'd0);
        chk("rd_ignored_collecting", collecting, 1'b0);
        tick();
        chk("rd_no_drain", out_valid, 1'b0);
        pulse_start();
        chk("rd_restart", collecting, 1'b1);
        chk("rd_restart_ovf", overflow, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/phase_collector.md
Name: phase_collector

Overview:
- Receiving end of the phase/step output stream. It consumes the per-beat {mem_op, mem_data} words produced by the Gaussian-elimination phase controller.
- Reassembles them into an L-row by K-column result buffer, organised as K/N column-block words of N bits per row.
- Once all L rows have arrived, replays the buffer row-major over a valid/ready stream to the host side.
- Also reports elimination failure and protocol violations.

Parameters:
- N, 4, lane count; bits per data beat (matches the phase/step column-block width)
- L, 8, number of result rows collected per run
- K, 16, columns per row; K/N must be an integer, giving column blocks per row

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle arm pulse: clears pointers and flags, enters COLLECT
- mem_data_in  in  N  data beat; bit i belongs to lane i
- mem_op_in  in  3N  per-lane op; lane i occupies bits [3i+2:3i]
- collecting  out  1  high while in COLLECT
- done  out  1  one-cycle pulse when row L-1 completes
- fail  out  1  sticky; a FAIL op was received this run
- err  out  1  sticky; protocol violation this run
- overflow  out  1  sticky; a non-IDLE beat arrived outside COLLECT
- rows_written  out  $clog2(L+1)  completed rows this run
- out_data  out  N  readout word
- out_valid  out  1  readout word valid
- out_ready  in  1  downstream accepts the word
- out_last  out  1  high with the final word (row L-1, block K/N-1)

Behaviour:

Reset (rst=0, asynchronous):
- State goes to IDLE.
- All outputs go to 0, including out_data.
- Pointers are cleared.
- Buffer contents are undefined.
- Reset asserted mid-COLLECT or mid-DRAIN aborts immediately. No done pulse is emitted.

Op encoding (lane 0 op is the beat op):
- 3'b000 IDLE: no effect.
- 3'b001 DATA: write the beat.
- 3'b011 DATA_LAST: write the beat and close the row.
- 3'b100 FAIL: set fail.
- Any other code sets err and the beat is discarded.
- Lanes 1..N-1 must equal lane 0. A mismatch sets err, but the beat is still processed using the lane 0 op.

States: IDLE, COLLECT, DRAIN.

IDLE:
- start goes to COLLECT next cycle.
- In the same cycle, row_ptr, col_ptr, rows_written, fail, err and overflow are cleared.

COLLECT:
- DATA: write mem_data_in to buffer[row_ptr][col_ptr].
  - If col_ptr==K/N-1: set err and hold col_ptr; the word is overwritten by later beats.
  - Otherwise col_ptr increments.
- DATA_LAST: write the word.
  - If col_ptr!=K/N-1, set err.
  - In either case col_ptr goes to 0, and row_ptr and rows_written increment.
- Completion: when the closed row is row L-1, done pulses the next cycle and the state goes to DRAIN.
- FAIL: sets fail, then DRAIN next cycle with the current partial buffer. done is not pulsed.
- start in COLLECT re-arms: pointers and flags are cleared and the state stays in COLLECT. A beat arriving in the same cycle is ignored.

DRAIN:
- The read pointer starts at word 0.
- out_valid rises exactly 1 cycle after entering DRAIN, with out_data = word 0.
- Transfer occurs when out_valid && out_ready. The next word is presented the following cycle, with no bubbles, so full rate is 1 word/cycle.
- When out_valid=1 && out_ready=0, out_data and out_last are held stable.
- Transfer of the out_last word: out_valid drops next cycle and the state returns to IDLE.
- After a FAIL, all L*K/N words are still drained. Unwritten words are undefined.
- start during DRAIN is ignored.

Outside COLLECT:
- A non-IDLE beat sets overflow and is dropped.
- overflow is not cleared until the next start.

Buffer:
- L*K/N words of N bits.
- Address = row*(K/N) + col.
- Single write port and single read port.
- Read-during-write cannot occur, since COLLECT and DRAIN are exclusive.

rows_written:
- Saturates at L.

Test Plan:
- Nominal: N=4, L=8, K=16. start, then 32 beats. Each row is DATA x3 then DATA_LAST, with data = address[3:0] -> done pulses 1 cycle after beat 32. rows_written=8. out_ready=1 streams 0,1,...,15,0,...,15 on 32 consecutive cycles. out_last only with the 32nd word. err=fail=overflow=0.
- Backpressure: as nominal, but out_ready toggles 1,0,0,1,... -> each word is held stable while out_ready=0, with no loss or duplication. Total of 32 transfers.
- Protocol errors: DATA_LAST at col 1, then lane 2 op=3'b011 while lane 0=3'b001 -> err=1 after the first violation. The short row still advances row_ptr (rows_written increments). err stays set through DRAIN. start clears it.
- Fail: FAIL after 3 complete rows -> fail=1, no done pulse. The state enters DRAIN and emits 32 words. The first 12 match the written data.
- Overflow and re-arm: a DATA beat in IDLE sets overflow=1. start clears it. start mid-COLLECT after 5 beats restarts writing at address 0, and the rest of the run completes normally.
- Reset mid-DRAIN: drop rst for 1 cycle after 10 transfers -> out_valid, out_data and all flags are 0 asynchronously. The state returns to IDLE. Stream beats are ignored until start.
